// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS core K/P inputs.
// Steps K from a start word toward a stop word with a programmable dwell (single, repeat, triangle).
module dds_sweep_ctrl #(
  parameter int unsigned KW = 32,
  parameter int unsigned PW = 11,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [KW-1:0] cfg_k_start,
  input  logic [KW-1:0] cfg_k_stop,
  input  logic [KW-1:0] cfg_k_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic [1:0]    cfg_mode,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  output logic [KW-1:0] K,
  output logic [PW-1:0] P,
  output logic          busy,
  output logic          done,
  output logic          dir
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] kStart_q, kStart_d;
  logic [KW-1:0] kStop_q, kStop_d;
  logic [KW-1:0] kStep_q, kStep_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    mode_q, mode_d;
  logic          cfgLoaded_q, cfgLoaded_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          retLeg_q, retLeg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [KW-1:0] endK;
  logic          initDir;

  // One step of cur toward tgt, clamped at tgt on overshoot or wrap.
  function automatic logic [KW-1:0] stepToward(input logic [KW-1:0] cur,
                                               input logic [KW-1:0] step,
                                               input logic [KW-1:0] tgt,
                                               input logic          up);
    logic [KW:0] r;
    if (up) begin
      r = {1'b0, cur} + {1'b0, step};
      stepToward = (r[KW] || (r[KW-1:0] >= tgt)) ? tgt : r[KW-1:0];
    end else begin
      r = {1'b0, cur} - {1'b0, step};
      stepToward = (r[KW] || (r[KW-1:0] <= tgt)) ? tgt : r[KW-1:0];
    end
  endfunction

  assign endK    = retLeg_q ? kStart_q : kStop_q;
  assign initDir = (kStop_q >= kStart_q);

  always_comb begin
    state_d     = state_q;
    kStart_d    = kStart_q;
    kStop_d     = kStop_q;
    kStep_d     = kStep_q;
    dwell_d     = dwell_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    cfgLoaded_d = cfgLoaded_q;
    k_d         = k_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    retLeg_d    = retLeg_q;

    unique case (state_q)
      IDLE: begin
        // A handshake in the same cycle as start wins; start is dropped.
        if (cfg_valid) begin
          kStart_d    = cfg_k_start;
          kStop_d     = cfg_k_stop;
          kStep_d     = cfg_k_step;
          dwell_d     = cfg_dwell;
          phase_d     = cfg_phase;
          mode_d      = cfg_mode;
          cfgLoaded_d = 1'b1;
        end else if (start && cfgLoaded_q) begin
          state_d  = RUN;
          k_d      = kStart_q;
          p_d      = phase_q;
          cnt_d    = dwell_q;
          dir_d    = initDir;
          retLeg_d = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = RUN;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else begin
          cnt_d = dwell_q;
          if (k_q == endK) begin
            unique case (mode_q)
              2'd1: begin
                k_d      = kStart_q;
                dir_d    = initDir;
                retLeg_d = 1'b0;
              end
              2'd2: begin
                dir_d    = ~dir_q;
                retLeg_d = ~retLeg_q;
                k_d      = stepToward(k_q, kStep_q, retLeg_q ? kStop_q : kStart_q, ~dir_q);
              end
              default: state_d = FINISH;
            endcase
          end else begin
            k_d = stepToward(k_q, kStep_q, endK, dir_q);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kStart_q    <= '0;
      kStop_q     <= '0;
      kStep_q     <= '0;
      dwell_q     <= '0;
      phase_q     <= '0;
      mode_q      <= '0;
      cfgLoaded_q <= 1'b0;
      k_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b1;
      retLeg_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kStart_q    <= kStart_d;
      kStop_q     <= kStop_d;
      kStep_q     <= kStep_d;
      dwell_q     <= dwell_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      cfgLoaded_q <= cfgLoaded_d;
      k_q         <= k_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      retLeg_q    <= retLeg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign K         = k_q;
  assign P         = p_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dir       = dir_q;

endmodule
